jump_resolve_buffer: RTL and testbench

Captures the one-cycle result pulse of the jump/branch functional unit and holds it in a small in-order buffer. It resolves each jump toward the front end (PC redirect plus taken/not-taken report to the scoreboard) and arbitrates the link-register write-back through a request/grant handshake with the register-file write port. It sits directly downstream of the jump FU and upstream of fetch redirect and write-back.

---
 rtl/jump_resolve_buffer_pkg.sv | 19 +
 rtl/jrb_fifo.sv | 57 +++++
 rtl/jump_resolve_buffer.sv | 112 +++++++++++
 tb/tb_jump_resolve_buffer.sv | 300 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/jump_resolve_buffer_pkg.sv
// Shared types for the jump resolve buffer:
// head FSM encoding and entry field layout.
package jump_resolve_buffer_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RD_W     = 5;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_RESOLVE = 2'd1,
    S_WB      = 2'd2
  } state_e;

  // {taken, target, link, rd, need_wb}
  function automatic int entry_w(int xlen);
    return 2 * xlen + RD_W + 2;
  endfunction

endpackage

// File: rtl/jrb_fifo.sv
// In-order entry storage with wrapping
// pointers and an occupancy counter.
module jrb_fifo #(
  parameter int DEPTH = 2,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push_i,
  input  logic         pop_i,
  input  logic [W-1:0] wdata_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wptr_q, wptr_d;
  logic [PW-1:0] rptr_q, rptr_d;
  logic [CW-1:0] cnt_q, cnt_d;

  always_ff @(posedge clk) begin
    if (push_i) mem_q[wptr_q] <= wdata_i;
  end

  always_comb begin
    wptr_d = push_i ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop_i  ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push_i, pop_i})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign rdata_o = mem_q[rptr_q];
  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/jump_resolve_buffer.sv
// Buffers jump FU results, resolves them toward
// fetch and arbitrates the link write-back.
module jump_resolve_buffer
  import jump_resolve_buffer_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int XLEN  = XLEN_DEF
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            fu_finish,
  input  logic [XLEN-1:0] fu_pc_jump,
  input  logic [XLEN-1:0] fu_pc_wb,
  input  logic            fu_cmp_res,
  input  logic            fu_is_branch,
  input  logic [RD_W-1:0] fu_rd,
  input  logic            wb_grant,
  output logic            ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            resolve_valid,
  output logic            resolve_taken,
  output logic            wb_req,
  output logic [RD_W-1:0] wb_rd,
  output logic [XLEN-1:0] wb_data,
  output logic            overflow
);

  localparam int EW = entry_w(XLEN);

  state_e          state_q, state_d;
  logic            full, empty, push, pop;
  logic [EW-1:0]   wdata, rdata;
  logic            in_taken, in_need_wb;
  logic            h_taken, h_need_wb;
  logic [XLEN-1:0] h_tgt, h_link;
  logic [RD_W-1:0] h_rd;
  logic            ovf_q, ovf_d;

  assign in_taken   = fu_is_branch ? fu_cmp_res : 1'b1;
  assign in_need_wb = !fu_is_branch && (fu_rd != '0);
  assign wdata = {in_taken, fu_pc_jump, fu_pc_wb, fu_rd, in_need_wb};
  assign {h_taken, h_tgt, h_link, h_rd, h_need_wb} = rdata;

  assign pop = (state_q == S_RESOLVE && !h_need_wb)
            || (state_q == S_WB && wb_grant);
  // A pop in the same cycle frees the slot for a new capture.
  assign push  = fu_finish && (!full || pop);
  assign ovf_d = ovf_q || (fu_finish && full && !pop);
  assign ready = !full;

  jrb_fifo #(
    .DEPTH(DEPTH),
    .W    (EW)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push_i (push),
    .pop_i  (pop),
    .wdata_i(wdata),
    .rdata_o(rdata),
    .full_o (full),
    .empty_o(empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:    if (!empty) state_d = S_RESOLVE;
      S_RESOLVE: state_d = h_need_wb ? S_WB : S_IDLE;
      S_WB:      if (wb_grant) state_d = S_IDLE;
      default:   state_d = S_IDLE;
    endcase
  end

  always_comb begin
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    resolve_valid  = 1'b0;
    resolve_taken  = 1'b0;
    wb_req         = 1'b0;
    wb_rd          = '0;
    wb_data        = '0;
    unique case (state_q)
      S_RESOLVE: begin
        resolve_valid  = 1'b1;
        resolve_taken  = h_taken;
        redirect_valid = h_taken;
        redirect_pc    = h_taken ? h_tgt : '0;
      end
      S_WB: begin
        wb_req  = 1'b1;
        wb_rd   = h_rd;
        wb_data = h_link;
      end
      default: ;
    endcase
  end

  assign overflow = ovf_q;

endmodule

// File: tb/tb_jump_resolve_buffer.sv
// Bench for jump_resolve_buffer: directed table,
// corner sequences and a queue-based random model.
module tb_jump_resolve_buffer;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        fu_finish;
  logic [31:0] fu_pc_jump;
  logic [31:0] fu_pc_wb;
  logic        fu_cmp_res;
  logic        fu_is_branch;
  logic [4:0]  fu_rd;
  logic        wb_grant;
  logic        ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        resolve_valid;
  logic        resolve_taken;
  logic        wb_req;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        overflow;

  always #5 clk = ~clk;

  jump_resolve_buffer #(.DEPTH(DEPTH), .XLEN(32)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .fu_finish     (fu_finish),
    .fu_pc_jump    (fu_pc_jump),
    .fu_pc_wb      (fu_pc_wb),
    .fu_cmp_res    (fu_cmp_res),
    .fu_is_branch  (fu_is_branch),
    .fu_rd         (fu_rd),
    .wb_grant      (wb_grant),
    .ready         (ready),
    .redirect_valid(redirect_valid),
    .redirect_pc   (redirect_pc),
    .resolve_valid (resolve_valid),
    .resolve_taken (resolve_taken),
    .wb_req        (wb_req),
    .wb_rd         (wb_rd),
    .wb_data       (wb_data),
    .overflow      (overflow)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h t=%0t", nm, got, exp, $time);
    end
  endtask

  // Reference: queue of pending jumps. The head spends one cycle
  // waiting, one cycle resolving, then (link entries only) waits
  // for a grant. age counts cycles the current head has been head.
  typedef struct {
    bit        taken;
    bit [31:0] tgt;
    bit [31:0] link;
    bit [4:0]  rd;
    bit        need_wb;
  } ment_t;

  ment_t mq[$];
  int    age;
  bit    movf;

  task automatic model_clear();
    mq.delete();
    age  = 0;
    movf = 0;
  endtask

  task automatic model_cmp();
    bit        res, wbp, rv;
    ment_t     h;
    res = 0;
    wbp = 0;
    if (mq.size() > 0) begin
      h   = mq[0];
      res = (age == 1);
      wbp = (age >= 2) && h.need_wb;
    end
    rv = res && h.taken;
    chk("m_ready", ready, 32'(mq.size() < DEPTH));
    chk("m_redirect_valid", redirect_valid, 32'(rv));
    chk("m_redirect_pc", redirect_pc, rv ? h.tgt : 32'h0);
    chk("m_resolve_valid", resolve_valid, 32'(res));
    chk("m_resolve_taken", resolve_taken, 32'(res && h.taken));
    chk("m_wb_req", wb_req, 32'(wbp));
    chk("m_wb_rd", wb_rd, wbp ? 32'(h.rd) : 32'h0);
    chk("m_wb_data", wb_data, wbp ? h.link : 32'h0);
    chk("m_overflow", overflow, 32'(movf));
  endtask

  task automatic model_update();
    bit    pop, cap;
    ment_t e;
    pop = 0;
    if (mq.size() > 0) begin
      if (age == 1 && !mq[0].need_wb) pop = 1;
      if (age >= 2 && wb_grant) pop = 1;
    end
    cap = fu_finish && (mq.size() < DEPTH || pop);
    if (fu_finish && !cap) movf = 1;
    if (pop) begin
      void'(mq.pop_front());
      age = 0;
    end else if (mq.size() > 0) begin
      age++;
    end
    if (cap) begin
      e.taken   = fu_is_branch ? fu_cmp_res : 1'b1;
      e.tgt     = fu_pc_jump;
      e.link    = fu_pc_wb;
      e.rd      = fu_rd;
      e.need_wb = !fu_is_branch && fu_rd != 0;
      mq.push_back(e);
    end
  endtask

  task automatic drive(input bit fu, input bit br, input bit cmp,
                       input bit [4:0] rd, input bit [31:0] tgt,
                       input bit [31:0] link, input bit gr);
    fu_finish    = fu;
    fu_is_branch = br;
    fu_cmp_res   = cmp;
    fu_rd        = rd;
    fu_pc_jump   = tgt;
    fu_pc_wb     = link;
    wb_grant     = gr;
  endtask

  // Called at posedge+1; checks this cycle, then steps one clock.
  task automatic step();
    model_cmp();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      step();
    end
  endtask

  task automatic do_reset();
    drive(0, 0, 0, 0, 0, 0, 0);
    rst_n = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit        fu, br, cmp;
    bit [4:0]  rd;
    bit [31:0] tgt, link;
    bit        gr;
    bit        rv;
    bit [31:0] rpc;
    bit        resv, rest, wbreq;
    bit [4:0]  wbrd;
    bit [31:0] wbd;
    bit        rdy;
  } vec_t;

  function automatic vec_t mk(bit fu, bit br, bit cmp, bit [4:0] rd,
                              bit [31:0] tgt, bit [31:0] link, bit gr,
                              bit rv, bit [31:0] rpc, bit resv,
                              bit rest, bit wbreq, bit [4:0] wbrd,
                              bit [31:0] wbd);
    vec_t v;
    v.fu = fu; v.br = br; v.cmp = cmp; v.rd = rd;
    v.tgt = tgt; v.link = link; v.gr = gr;
    v.rv = rv; v.rpc = rpc; v.resv = resv; v.rest = rest;
    v.wbreq = wbreq; v.wbrd = wbrd; v.wbd = wbd; v.rdy = 1;
    return v;
  endfunction

  vec_t tbl[$];

  initial begin
    rst_n = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0);
    model_clear();
    #3;
    model_cmp();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    idle(10);

    // JAL rd=1: redirect 2 cycles after capture, then link write-back
    tbl.push_back(mk(1,0,0,1,32'h100,32'h44,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,  1,32'h100,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,1,1,32'h44));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,1,1,32'h44));
    tbl.push_back(mk(0,0,0,0,0,0,1,           0,0,0,0,1,1,32'h44));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    // not-taken branch; stray grant while empty is ignored
    tbl.push_back(mk(1,1,0,3,32'h200,32'h48,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,1,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,1,           0,0,0,0,0,0,0));
    // JALR rd=0: redirect only
    tbl.push_back(mk(1,0,1,0,32'h300,32'h4c,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,  1,32'h300,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    // taken branch with rd!=0: no write-back
    tbl.push_back(mk(1,1,1,5,32'h600,32'h50,0, 0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,  1,32'h600,1,1,0,0,0));
    tbl.push_back(mk(0,0,0,0,0,0,0,           0,0,0,0,0,0,0));

    foreach (tbl[i]) begin
      drive(tbl[i].fu, tbl[i].br, tbl[i].cmp, tbl[i].rd,
            tbl[i].tgt, tbl[i].link, tbl[i].gr);
      chk("t_redirect_valid", redirect_valid, 32'(tbl[i].rv));
      chk("t_redirect_pc", redirect_pc, tbl[i].rpc);
      chk("t_resolve_valid", resolve_valid, 32'(tbl[i].resv));
      chk("t_resolve_taken", resolve_taken, 32'(tbl[i].rest));
      chk("t_wb_req", wb_req, 32'(tbl[i].wbreq));
      chk("t_wb_rd", wb_rd, 32'(tbl[i].wbrd));
      chk("t_wb_data", wb_data, tbl[i].wbd);
      chk("t_ready", ready, 32'(tbl[i].rdy));
      step();
    end

    // back-to-back captures, grant withheld, third capture overflows
    for (int c = 0; c < 14; c++) begin
      drive(0, 0, 0, 0, 0, 0, 0);
      if (c == 0) drive(1, 0, 0, 1, 32'h400, 32'h10, 0);
      if (c == 1) drive(1, 0, 0, 2, 32'h500, 32'h14, 0);
      if (c == 3) drive(1, 0, 0, 3, 32'h700, 32'h18, 0);
      if (c == 8 || c == 11) wb_grant = 1'b1;
      if (c == 2 || c == 4) chk("full_ready", ready, 0);
      if (c >= 4) chk("ovf_sticky", overflow, 1);
      if (c >= 3 && c <= 8) chk("hold_wb_rd", wb_rd, 1);
      if (c >= 3 && c <= 9) chk("no_early_res", resolve_valid, 0);
      if (c == 10) chk("second_pc", redirect_pc, 32'h500);
      if (c == 11) chk("second_rd", wb_rd, 2);
      step();
    end
    idle(3);

    // reset while a write-back is pending
    do_reset();
    chk("ovf_cleared", overflow, 0);
    drive(1, 0, 0, 7, 32'h800, 32'h1c, 0);
    step();
    idle(2);
    chk("pre_rst_wb_req", wb_req, 1);
    #2;
    rst_n = 1'b0;
    model_clear();
    #1;
    chk("rst_wb_req", wb_req, 0);
    chk("rst_wb_data", wb_data, 0);
    chk("rst_wb_rd", wb_rd, 0);
    chk("rst_ready", ready, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    drive(0, 0, 0, 0, 0, 0, 1);
    step();
    idle(4);

    // random traffic against the queue model
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 9) < 4, $urandom_range(0, 1),
            $urandom_range(0, 1), 5'($urandom_range(0, 3)),
            $urandom, $urandom, $urandom_range(0, 1));
      step();
    end
    idle(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
